// File: rtl/clock_period_meter.sv
// Measures period and high time of a slow asynchronous square wave in clock_in cycles,
// with a one-cycle valid pulse per measurement and a stall timeout.
module clock_period_meter #(
    parameter int unsigned     WIDTH   = 32,
    parameter longint unsigned TIMEOUT = 50_000_000
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic             enable,
    input  logic             clock_sample,
    output logic             edge_pulse,
    output logic [WIDTH-1:0] period_out,
    output logic [WIDTH-1:0] high_out,
    output logic             period_valid,
    output logic             timeout
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARM     = 2'd1;
    localparam logic [1:0] ST_MEASURE = 2'd2;

    localparam logic [WIDTH-1:0] TMO_LAST = WIDTH'(TIMEOUT - 1);

    logic             s1_q, s2_q, prev_q;
    logic             rise;
    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] per_q, per_d;
    logic [WIDTH-1:0] high_q, high_d;
    logic             valid_q, valid_d;
    logic             tmo_q, tmo_d;
    logic             edge_q, edge_d;

    // Two-flop synchronizer plus one history flop for edge detection.
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            s1_q   <= clock_sample;
            s2_q   <= s1_q;
            prev_q <= s2_q;
        end
    end

    assign rise = s2_q & ~prev_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        per_d   = per_q;
        high_d  = high_q;
        valid_d = 1'b0;
        tmo_d   = tmo_q;
        edge_d  = enable & rise;

        if (!enable) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            hi_d    = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_d   = '0;
                    hi_d    = '0;
                    state_d = ST_ARM;
                end
                ST_ARM: begin
                    if (rise) begin
                        cnt_d   = '0;
                        hi_d    = WIDTH'(1);
                        tmo_d   = 1'b0;
                        state_d = ST_MEASURE;
                    end else if (cnt_q == TMO_LAST) begin
                        tmo_d = 1'b1;
                        cnt_d = '0;
                        hi_d  = '0;
                    end else begin
                        cnt_d = cnt_q + WIDTH'(1);
                    end
                end
                ST_MEASURE: begin
                    // A rise takes priority over a coincident timeout.
                    if (rise) begin
                        per_d   = cnt_q + WIDTH'(1);
                        high_d  = hi_q;
                        valid_d = 1'b1;
                        cnt_d   = '0;
                        hi_d    = WIDTH'(1);
                    end else if (cnt_q == TMO_LAST) begin
                        tmo_d   = 1'b1;
                        cnt_d   = '0;
                        hi_d    = '0;
                        state_d = ST_ARM;
                    end else begin
                        cnt_d = cnt_q + WIDTH'(1);
                        hi_d  = hi_q + WIDTH'(s2_q);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    hi_d    = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            per_q   <= '0;
            high_q  <= '0;
            valid_q <= 1'b0;
            tmo_q   <= 1'b0;
            edge_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            per_q   <= per_d;
            high_q  <= high_d;
            valid_q <= valid_d;
            tmo_q   <= tmo_d;
            edge_q  <= edge_d;
        end
    end

    assign edge_pulse   = edge_q;
    assign period_out   = per_q;
    assign high_out     = high_q;
    assign period_valid = valid_q;
    assign timeout      = tmo_q;

endmodule
